// File: rtl/mips_mem_pkg.sv
// Shared types for the core's data-memory port: byte-lane word, responder FSM states.
package mips_mem_pkg;

   localparam int unsigned WORD_BYTES = 4;

   typedef logic [7:0] word_bytes_t [0:WORD_BYTES-1];

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array: write-enabled store, registered read, no reset.
module mem_array #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Data-port responder: latches every access in IDLE, holds it LATENCY cycles,
// then commits to the word array and pulses mem_ready with the result.
module data_memory
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [31:0] mem_addr,
   input  word_bytes_t mem_data_in,
   input  logic        mem_write_en,
   output word_bytes_t mem_data_out,
   output logic        mem_ready
);

   localparam int unsigned WORD_W = 8 * WORD_BYTES;
   localparam int unsigned CNT_W  = 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   mem_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [WORD_W-1:0]     wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [WORD_W-1:0]     dout_q, dout_d;
   logic                  ready_q, ready_d;

   logic [ADDR_WIDTH-1:0] arr_addr_c;
   logic                  arr_we_c;
   logic [WORD_W-1:0]     din_c;
   logic [WORD_W-1:0]     rdata_c;
   logic                  unused_c;

   // Byte offset and bits above the word index are don't-care (addresses alias).
   assign unused_c = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

   // Lane 0 is the most-significant byte.
   always_comb begin
      din_c = '0;
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         din_c[WORD_W-1-8*i -: 8] = mem_data_in[i];
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         mem_data_out[i] = dout_q[WORD_W-1-8*i -: 8];
      end
   end

   assign mem_ready = ready_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         dout_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
      end
   end

   // The array is addressed by the live input in IDLE so its registered read
   // is already valid by the commit edge even at LATENCY=1.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      dout_d     = dout_q;
      ready_d    = 1'b0;
      arr_we_c   = 1'b0;
      arr_addr_c = idx_q;
      unique case (state_q)
         IDLE: begin
            idx_d      = mem_addr[ADDR_WIDTH+1:2];
            wdata_d    = din_c;
            we_d       = mem_write_en;
            cnt_d      = CNT_LOAD;
            state_d    = BUSY;
            arr_addr_c = mem_addr[ADDR_WIDTH+1:2];
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
               if (we_q) begin
                  arr_we_c = 1'b1;
                  dout_d   = wdata_q;
               end else begin
                  dout_d   = rdata_c;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   mem_array #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(WORD_W)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we_c),
      .addr_i  (arr_addr_c),
      .wdata_i (wdata_q),
      .rdata_o (rdata_c)
   );

endmodule
